uart_tx_queue: RTL and testbench

- Byte queue and transmit sequencer that sits directly upstream of the UART transmitter.
- Producers push bytes at full clock rate. The block buffers them in a FIFO and hands them to the transmitter one at a time over the trmt/tx_data/tx_done handshake.
- Decouples bursty command/telemetry writers from the 10-bit-frame UART (2604 clk per bit, 26040 clk per byte).

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_tx_queue_if.sv | 38 +++
 rtl/sync_fifo.sv | 78 +++++++
 rtl/uart_tx_queue.sv | 106 ++++++++++
 tb/tb_uart_tx_queue.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// ============================================================================
//  Package     : uart_pkg
//  Description : Shared types and frame timing constants for the UART TX path.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        BUSY = 2'd2
    } txq_state_e;

    localparam int BAUD_DIV   = 2604;
    localparam int FRAME_BITS = 10;

endpackage

`default_nettype wire

// File: rtl/uart_tx_queue_if.sv
// ============================================================================
//  Interface   : uart_tx_queue_if
//  Description : Producer write port, queue status and transmitter handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_tx_queue_if
    import uart_pkg::*;
#(
    parameter int DEPTH = 8
) ();
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             wr_en;
    logic [7:0]       wr_data;
    logic             flush;
    logic             full;
    logic             empty;
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic             trmt;
    logic [7:0]       tx_data;
    logic             tx_done;

    modport master (
        output wr_en, wr_data, flush, tx_done,
        input  full, empty, count, overflow, trmt, tx_data
    );

    modport slave (
        input  wr_en, wr_data, flush, tx_done,
        output full, empty, count, overflow, trmt, tx_data
    );

endinterface

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
//  Module      : sync_fifo
//  Description : Circular-buffer FIFO with occupancy count and sync flush.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo #(
    parameter  int DEPTH = 8,
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             wr_en_i,
    input  wire logic [WIDTH-1:0] wr_data_i,
    input  wire logic             rd_en_i,
    input  wire logic             flush_i,
    output logic      [WIDTH-1:0] rd_data_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic      [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             w_do_rd;
    logic             w_do_wr;

    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign rd_data_o = mem_q[rd_ptr_q];

    // A pop in the same cycle frees the slot, so a full FIFO still accepts it.
    assign w_do_rd = rd_en_i && !empty_o;
    assign w_do_wr = wr_en_i && (!full_o || w_do_rd);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (w_do_wr) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (w_do_rd) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (w_do_wr && !w_do_rd)      count_d = count_q + CNT_W'(1);
            else if (w_do_rd && !w_do_wr) count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !flush_i && w_do_wr) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_tx_queue.sv
// ============================================================================
//  Module      : uart_tx_queue
//  Description : Byte queue feeding a UART transmitter via trmt/tx_done.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_queue
    import uart_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  wire logic        clk,
    input  wire logic        rst,
    uart_tx_queue_if.slave   bus
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    txq_state_e       state_q, state_d;
    logic             trmt_q, trmt_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             overflow_q, overflow_d;
    logic             w_pop;
    logic [7:0]       w_head;
    logic             w_full;
    logic             w_empty;
    logic [CNT_W-1:0] w_count;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (bus.wr_en),
        .wr_data_i (bus.wr_data),
        .rd_en_i   (w_pop),
        .flush_i   (bus.flush),
        .rd_data_o (w_head),
        .full_o    (w_full),
        .empty_o   (w_empty),
        .count_o   (w_count)
    );

    assign bus.full     = w_full;
    assign bus.empty    = w_empty;
    assign bus.count    = w_count;
    assign bus.overflow = overflow_q;
    assign bus.trmt     = trmt_q;
    assign bus.tx_data  = tx_data_q;

    // Only a write lost to a full FIFO counts; flush discards are intentional.
    assign overflow_d = overflow_q
                      | (bus.wr_en && w_full && !w_pop && !bus.flush);

    always_comb begin
        state_d   = state_q;
        trmt_d    = 1'b0;
        tx_data_d = tx_data_q;
        w_pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!w_empty) begin
                    w_pop     = 1'b1;
                    tx_data_d = w_head;
                    trmt_d    = 1'b1;
                    state_d   = SEND;
                end
            end
            SEND: begin
                state_d = BUSY;
            end
            BUSY: begin
                if (bus.tx_done) begin
                    if (!w_empty) begin
                        w_pop     = 1'b1;
                        tx_data_d = w_head;
                        trmt_d    = 1'b1;
                        state_d   = SEND;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            trmt_q     <= 1'b0;
            tx_data_q  <= 8'h00;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            trmt_q     <= trmt_d;
            tx_data_q  <= tx_data_d;
            overflow_q <= overflow_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_queue.sv
// ============================================================================
//  Module      : tb_uart_tx_queue
//  Description : Scoreboard bench with a bit-serial transmitter and receiver.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_queue;
    import uart_pkg::*;

    localparam int DEPTH    = 8;
    localparam int CNT_W    = $clog2(DEPTH + 1);
    // Bit period shortened from BAUD_DIV so full bursts fit a short run.
    localparam int BIT_CLKS = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_tx_queue_if #(.DEPTH(DEPTH)) bus ();

    uart_tx_queue #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int         n_checks = 0;
    int         n_errors = 0;
    int         trmt_cnt = 0;
    logic       prev_trmt = 1'b0;
    logic [7:0] exp_q [$];
    logic [7:0] rx_got [$];
    logic [7:0] exp_b;
    logic       xmtr_en = 1'b0;
    logic       man_done = 1'b0;

    // Behavioural transmitter: shifts {stop, data, start} LSB first.
    logic       m_busy, m_done, line;
    logic [9:0] m_shift;
    int         m_cnt, m_bit;
    assign line        = m_busy ? m_shift[0] : 1'b1;
    assign bus.tx_done = xmtr_en ? m_done : man_done;

    always @(posedge clk) begin
        if (rst) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_cnt <= 0; m_bit <= 0; m_shift <= '1;
        end else if (bus.trmt) begin
            m_shift <= {1'b1, bus.tx_data, 1'b0};
            m_busy  <= 1'b1; m_done <= 1'b0; m_cnt <= 0; m_bit <= 0;
        end else if (m_busy) begin
            if (m_cnt == BIT_CLKS - 1) begin
                m_cnt   <= 0;
                m_shift <= {1'b1, m_shift[9:1]};
                if (m_bit == FRAME_BITS - 1) begin
                    m_busy <= 1'b0; m_done <= 1'b1;
                end else begin
                    m_bit <= m_bit + 1;
                end
            end else begin
                m_cnt <= m_cnt + 1;
            end
        end
    end

    // Serial receiver sampling mid-bit
    int         r_st, r_cnt, r_k;
    logic [7:0] r_byte;
    always @(posedge clk) begin
        if (rst) begin
            r_st <= 0; r_cnt <= 0;
        end else if (r_st == 0) begin
            if (!line) begin r_st <= 1; r_cnt <= 1; end
        end else begin
            r_cnt <= r_cnt + 1;
            if (r_cnt % BIT_CLKS == BIT_CLKS / 2) begin
                r_k = r_cnt / BIT_CLKS;
                if (r_k >= 1 && r_k <= 8) r_byte[r_k-1] <= line;
                if (r_k == FRAME_BITS - 1) begin
                    rx_got.push_back(r_byte);
                    r_st <= 0;
                end
            end
        end
    end

    // Every trmt pulse pops the scoreboard and checks width and byte
    always @(negedge clk) begin
        if (bus.trmt === 1'b1) begin
            trmt_cnt++;
            n_checks++;
            if (prev_trmt) begin
                n_errors++;
                $display("FAIL trmt_width: trmt high 2+ cycles, required 1");
            end
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_trmt: tx_data=%h, required no trmt", bus.tx_data);
            end else begin
                exp_b = exp_q.pop_front();
                if (bus.tx_data !== exp_b) begin
                    n_errors++;
                    $display("FAIL tx_data: got %h, required %h", bus.tx_data, exp_b);
                end
            end
        end
        prev_trmt = (bus.trmt === 1'b1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int got, input int req);
        n_checks++;
        if (got !== req) begin
            n_errors++;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end
    endtask

    task automatic do_reset();
        step(); rst = 1'b1; bus.wr_en = 1'b0; bus.flush = 1'b0;
        step(); step(); rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic write_seq(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            step();
            bus.wr_en   = 1'b1;
            bus.wr_data = first + 8'(i);
            exp_q.push_back(first + 8'(i));
        end
        step();
        bus.wr_en = 1'b0;
    endtask

    task automatic wait_state(input txq_state_e s, input int budget);
        int t = 0;
        @(negedge clk);
        while (dut.state_q !== s && t < budget) begin @(negedge clk); t++; end
        n_checks++;
        if (dut.state_q !== s) begin
            n_errors++;
            $display("FAIL wait_state: state=%0d, required %0d", dut.state_q, s);
        end
    endtask

    task automatic wait_trmts(input int target, input int budget);
        int t = 0;
        @(negedge clk);
        while (trmt_cnt < target && t < budget) begin @(negedge clk); t++; end
        n_checks++;
        if (trmt_cnt < target) begin
            n_errors++;
            $display("FAIL wait_trmt: trmt count %0d, required %0d", trmt_cnt, target);
        end
    endtask

    task automatic pulse_done();
        wait_state(BUSY, 50);
        step(); man_done = 1'b1;
        step(); man_done = 1'b0;
    endtask

    task automatic test_reset();
        man_done = 1'b0; xmtr_en = 1'b0;
        bus.wr_en = 1'b0; bus.flush = 1'b0; bus.wr_data = 8'h00;
        rst = 1'b1;
        step(); step();
        @(negedge clk);
        chk("rst_empty",    int'(bus.empty),    1);
        chk("rst_full",     int'(bus.full),     0);
        chk("rst_count",    int'(bus.count),    0);
        chk("rst_overflow", int'(bus.overflow), 0);
        chk("rst_trmt",     int'(bus.trmt),     0);
        chk("rst_tx_data",  int'(bus.tx_data),  0);
        chk("rst_state",    int'(dut.state_q),  int'(IDLE));
        step(); rst = 1'b0;
    endtask

    task automatic test_single();
        int base = trmt_cnt;
        write_seq(8'hA5, 1);
        @(negedge clk);
        chk("single_count_n1", int'(bus.count), 1);
        chk("single_trmt_n1",  int'(bus.trmt),  0);
        @(negedge clk);
        chk("single_trmt_n2",  int'(bus.trmt),  1);
        chk("single_data_n2",  int'(bus.tx_data), 8'hA5);
        @(negedge clk);
        chk("single_count_n3", int'(bus.count), 0);
        chk("single_trmt_n3",  int'(bus.trmt),  0);
        repeat (30) @(negedge clk);
        chk("single_no_retrmt", trmt_cnt, base + 1);
        chk("single_busy",      int'(dut.state_q), int'(BUSY));
        pulse_done();
        wait_state(IDLE, 5);
    endtask

    task automatic test_burst();
        int base;
        do_reset();
        xmtr_en = 1'b1;
        rx_got.delete();
        base = trmt_cnt;
        // Nine writes: one goes straight to the transmitter, eight fill the FIFO.
        write_seq(8'h01, 9);
        @(negedge clk);
        chk("burst_full",  int'(bus.full),  1);
        chk("burst_count", int'(bus.count), DEPTH);
        wait_trmts(base + 2, 400);
        chk("burst_full_drop", int'(bus.full), 0);
        wait_trmts(base + 9, 3000);
        wait_state(IDLE, 400);
        chk("burst_trmt_total", trmt_cnt, base + 9);
        chk("burst_rx_size", rx_got.size(), 9);
        if (rx_got.size() == 9)
            for (int i = 0; i < 9; i++) chk("burst_rx_byte", int'(rx_got[i]), i + 1);
        chk("burst_sb_drained", exp_q.size(), 0);
        xmtr_en = 1'b0;
    endtask

    task automatic test_overflow();
        do_reset();
        man_done = 1'b0;
        write_seq(8'h10, 9);
        step(); bus.wr_en = 1'b1; bus.wr_data = 8'hFF;
        step(); bus.wr_en = 1'b0;
        @(negedge clk);
        chk("ovf_count",    int'(bus.count),    DEPTH);
        chk("ovf_full",     int'(bus.full),     1);
        chk("ovf_flag",     int'(bus.overflow), 1);
        repeat (9) pulse_done();
        wait_state(IDLE, 50);
        chk("ovf_empty",       int'(bus.empty),    1);
        chk("ovf_sticky",      int'(bus.overflow), 1);
        chk("ovf_sb_drained",  exp_q.size(),       0);
    endtask

    task automatic test_simul();
        do_reset();
        man_done = 1'b0;
        write_seq(8'h20, 9);
        wait_state(BUSY, 20);
        chk("simul_full_pre", int'(bus.full), 1);
        step(); man_done = 1'b1; bus.wr_en = 1'b1; bus.wr_data = 8'h55;
        exp_q.push_back(8'h55);
        step(); man_done = 1'b0; bus.wr_en = 1'b0;
        @(negedge clk);
        chk("simul_count", int'(bus.count), DEPTH);
        chk("simul_trmt",  int'(bus.trmt),  1);
        repeat (9) pulse_done();
        wait_state(IDLE, 50);
        chk("simul_sb_drained", exp_q.size(),       0);
        chk("simul_no_ovf",     int'(bus.overflow), 0);
    endtask

    task automatic test_flush();
        int base;
        do_reset();
        man_done = 1'b0;
        base = trmt_cnt;
        write_seq(8'h31, 3);
        wait_state(BUSY, 20);
        step(); bus.flush = 1'b1;
        step(); bus.flush = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("flush_empty", int'(bus.empty),   1);
        chk("flush_count", int'(bus.count),   0);
        chk("flush_busy",  int'(dut.state_q), int'(BUSY));
        pulse_done();
        wait_state(IDLE, 10);
        repeat (20) @(negedge clk);
        chk("flush_no_trmt", trmt_cnt, base + 1);
        chk("flush_idle",    int'(dut.state_q), int'(IDLE));
    endtask

    task automatic test_reset_mid();
        int base;
        do_reset();
        man_done = 1'b0;
        write_seq(8'h41, 5);
        wait_state(BUSY, 20);
        chk("rmid_count_pre", int'(bus.count), 4);
        step(); rst = 1'b1;
        step(); rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("rmid_trmt",  int'(bus.trmt),    0);
        chk("rmid_empty", int'(bus.empty),   1);
        chk("rmid_count", int'(bus.count),   0);
        chk("rmid_state", int'(dut.state_q), int'(IDLE));
        base = trmt_cnt;
        write_seq(8'h3C, 1);
        wait_trmts(base + 1, 10);
        chk("rmid_sb_drained", exp_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_overflow();
        test_simul();
        test_flush();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
